// File: rtl/axi_rd_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter_if
// Purpose : One AXI read path, covering the AR address channel and the R data
//           channel. The arbiter has three of them: two requester-facing
//           paths (m0, m1) and one bridge-facing path (s).
// Modports:
//   master - the side that issues reads. It drives araddr, arlen, arvalid
//            and rready, and receives arready, rdata, rresp, rlast and rvalid.
//   slave  - the side that serves reads, with every direction reversed.
// Signals :
//   araddr [ADDR_W] read address      arlen [LEN_W] burst length-1
//   arvalid/arready  AR handshake      rdata [DATA_W] read data
//   rresp [2]        read response     rlast          last beat
//   rvalid/rready    R handshake
// ---------------------------------------------------------------------------
interface axi_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) ();

  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  // The requester drives the address and the data-ready signal.
  modport master (
    output araddr, arlen, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  // The responder accepts the address and returns the data beats.
  modport slave (
    input  araddr, arlen, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
// Purpose : Arbitrates two AXI read requesters onto one read port of the
//           shared SRAM bridge. Only one transaction is outstanding at a time.
//           The winner keeps the bridge from its AR handshake until the beat
//           that carries rlast, and R beats are routed back only to that
//           master. Ties go round-robin by default.
// Ports   :
//   clk     in   clock; all logic runs on the rising edge
//   resetn  in   synchronous active-low reset
//   m0, m1  slave modport of axi_rd_arbiter_if   requester-facing read paths
//   s       master modport of axi_rd_arbiter_if  bridge-facing read path
//   busy    out  high while a transaction owns the bridge (ADDR or DATA)
// Config  : Define AXI_RD_ARB_FIXED_PRIO_EN to make m0 win every tie. That
//           build has no last-served register, so m1 is granted only when
//           m0 is not requesting.
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic             clk,
  input  logic             resetn,
  axi_rd_arbiter_if.slave  m0,
  axi_rd_arbiter_if.slave  m1,
  axi_rd_arbiter_if.master s,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e            r_state;
  state_e            w_nextState;
  logic              r_gnt;
  logic              w_nextGnt;
  logic              w_tieGnt;
  logic              w_selArvalid;
  logic              w_selRready;
  logic [ADDR_W-1:0] w_selAraddr;
  logic [LEN_W-1:0]  w_selArlen;

`ifndef AXI_RD_ARB_FIXED_PRIO_EN
  logic              r_last;
  logic              w_nextLast;
`endif

  // These are the request-side signals of whichever master currently holds
  // the grant. Both the next-state logic and the output muxes read them.
  assign w_selArvalid = r_gnt ? m1.arvalid : m0.arvalid;
  assign w_selRready  = r_gnt ? m1.rready  : m0.rready;
  assign w_selAraddr  = r_gnt ? m1.araddr  : m0.araddr;
  assign w_selArlen   = r_gnt ? m1.arlen   : m0.arlen;

  // When both masters request at once, the winner is the one that was not
  // served last (round-robin), or always m0 in the fixed-priority build.
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
  assign w_tieGnt = 1'b0;
`else
  assign w_tieGnt = ~r_last;
`endif

  // State register. Reset is synchronous and abandons any transaction in
  // flight. Clearing last to 1 lets m0 win the first tie after reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_gnt   <= 1'b0;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
      r_last  <= 1'b1;
`endif
    end else begin
      r_state <= w_nextState;
      r_gnt   <= w_nextGnt;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
      r_last  <= w_nextLast;
`endif
    end
  end

  // Next-state logic. The grant is decided only in IDLE, so a request that
  // arrives during a transaction waits, and back-to-back reads always pass
  // through one IDLE cycle. The last-served master is recorded only when its
  // final R beat completes.
  always_comb begin
    w_nextState = r_state;
    w_nextGnt   = r_gnt;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
    w_nextLast  = r_last;
`endif
    case (r_state)
      IDLE: begin
        if (m0.arvalid && m1.arvalid) begin
          w_nextGnt   = w_tieGnt;
          w_nextState = ADDR;
        end else if (m0.arvalid) begin
          w_nextGnt   = 1'b0;
          w_nextState = ADDR;
        end else if (m1.arvalid) begin
          w_nextGnt   = 1'b1;
          w_nextState = ADDR;
        end
      end
      ADDR: begin
        if (w_selArvalid && s.arready) begin
          w_nextState = DATA;
        end
      end
      DATA: begin
        if (s.rvalid && w_selRready && s.rlast) begin
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
          w_nextLast  = r_gnt;
`endif
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Output muxing. In ADDR only the AR channel is connected, to the granted
  // master. In DATA only the R channel is connected, back to that same
  // master. The other master sees zeros throughout. Every output is held at
  // zero while reset is asserted, so the ports go quiet in the same cycle
  // that reset is applied, even before the state register has cleared.
  // A stray s.rvalid outside DATA is ignored because s.rready stays 0.
  always_comb begin
    s.araddr   = '0;
    s.arlen    = '0;
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    m0.arready = 1'b0;
    m0.rdata   = '0;
    m0.rresp   = '0;
    m0.rlast   = 1'b0;
    m0.rvalid  = 1'b0;
    m1.arready = 1'b0;
    m1.rdata   = '0;
    m1.rresp   = '0;
    m1.rlast   = 1'b0;
    m1.rvalid  = 1'b0;
    busy       = 1'b0;
    if (resetn) begin
      case (r_state)
        ADDR: begin
          busy      = 1'b1;
          s.araddr  = w_selAraddr;
          s.arlen   = w_selArlen;
          s.arvalid = w_selArvalid;
          if (r_gnt) begin
            m1.arready = s.arready;
          end else begin
            m0.arready = s.arready;
          end
        end
        DATA: begin
          busy     = 1'b1;
          s.rready = w_selRready;
          if (r_gnt) begin
            m1.rvalid = s.rvalid;
            m1.rdata  = s.rdata;
            m1.rresp  = s.rresp;
            m1.rlast  = s.rlast;
          end else begin
            m0.rvalid = s.rvalid;
            m0.rdata  = s.rdata;
            m0.rresp  = s.rresp;
            m0.rlast  = s.rlast;
          end
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arbiter
// Purpose : Self-checking bench for axi_rd_arbiter. The bench drives the two
//           requesters from per-master request queues and plays the bridge
//           itself. A transaction-level model decides who owns the bridge and
//           whether the owner is in its address or data phase. From that, a
//           compare process derives every DUT output on each falling edge.
//           Directed scenarios add hand-computed literal checks on grant
//           order, data and latency.
// Config  : Define AXI_RD_ARB_FIXED_PRIO_EN for both the RTL and this bench
//           to build the fixed-priority variant.
// ---------------------------------------------------------------------------
module tb_axi_rd_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic busy;

  axi_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) m0If ();
  axi_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) m1If ();
  axi_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) sIf ();

  axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .resetn(resetn),
    .m0    (m0If),
    .m1    (m1If),
    .s     (sIf),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Records one comparison and reports any difference.
  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  // The bench plays the bridge. It accepts an address whenever it is idle
  // and not stalled, then returns arlen+1 beats. Beat i of a read at address
  // A carries data 0x12345678 + A + i, and the response field carries the
  // low two bits of i. Setting spurious forces rvalid high while the bridge
  // is idle.
  int          brBeats = 0;
  int          brIdx = 0;
  logic [31:0] brAddr = '0;
  logic        spurious = 1'b0;
  logic        arStall = 1'b0;

  assign sIf.arready = (brBeats == 0) && !arStall;
  assign sIf.rvalid  = (brBeats != 0) || spurious;
  assign sIf.rdata   = 32'h12345678 + brAddr + 32'(brIdx);
  assign sIf.rresp   = brIdx[1:0];
  assign sIf.rlast   = (brBeats == 1);

  always @(posedge clk) begin
    if (!resetn) begin
      brBeats <= 0;
      brIdx   <= 0;
      brAddr  <= '0;
    end else if (sIf.arvalid && sIf.arready) begin
      brBeats <= int'(sIf.arlen) + 1;
      brAddr  <= sIf.araddr;
      brIdx   <= 0;
    end else if (sIf.rvalid && sIf.rready && brBeats != 0) begin
      brBeats <= brBeats - 1;
      brIdx   <= brIdx + 1;
    end
  end

  // Accessors that select a requester's input by master index.
  function automatic logic mArvalid(int m);
    return (m == 1) ? m1If.arvalid : m0If.arvalid;
  endfunction
  function automatic logic mRready(int m);
    return (m == 1) ? m1If.rready : m0If.rready;
  endfunction
  function automatic logic [ADDR_W-1:0] mAraddr(int m);
    return (m == 1) ? m1If.araddr : m0If.araddr;
  endfunction
  function automatic logic [LEN_W-1:0] mArlen(int m);
    return (m == 1) ? m1If.arlen : m0If.arlen;
  endfunction

  // Transaction model. mdlOwner is the master holding the bridge, or -1 if
  // none does. mdlAddr is set while the owner's address is not yet accepted.
  // mdlLast is the master whose read completed most recently.
  int mdlOwner = -1;
  bit mdlAddr = 1'b0;
  int mdlLast = 1;

  always @(posedge clk) begin
    if (!resetn) begin
      mdlOwner <= -1;
      mdlAddr  <= 1'b0;
      mdlLast  <= 1;
    end else if (mdlOwner < 0) begin
      if (m0If.arvalid && m1If.arvalid) begin
        mdlOwner <= FIXED_PRIO ? 0 : 1 - mdlLast;
        mdlAddr  <= 1'b1;
      end else if (m0If.arvalid) begin
        mdlOwner <= 0;
        mdlAddr  <= 1'b1;
      end else if (m1If.arvalid) begin
        mdlOwner <= 1;
        mdlAddr  <= 1'b1;
      end
    end else if (mdlAddr) begin
      if (mArvalid(mdlOwner) && sIf.arready) mdlAddr <= 1'b0;
    end else if (sIf.rvalid && mRready(mdlOwner) && sIf.rlast) begin
      mdlLast  <= mdlOwner;
      mdlOwner <= -1;
    end
  end

  // Builds the full expected output word from the model state and the
  // current inputs.
  function automatic logic [116:0] expectedOutputs();
    logic [ADDR_W-1:0] eAraddr;
    logic [LEN_W-1:0]  eArlen;
    logic              eArvalid, eRready, eBusy;
    logic              eArready [2];
    logic [DATA_W-1:0] eRdata   [2];
    logic [1:0]        eRresp   [2];
    logic              eRlast   [2];
    logic              eRvalid  [2];
    eAraddr = '0; eArlen = '0; eArvalid = 1'b0; eRready = 1'b0; eBusy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      eArready[i] = 1'b0; eRdata[i] = '0; eRresp[i] = '0;
      eRlast[i] = 1'b0; eRvalid[i] = 1'b0;
    end
    if (resetn && mdlOwner >= 0) begin
      eBusy = 1'b1;
      if (mdlAddr) begin
        eAraddr            = mAraddr(mdlOwner);
        eArlen             = mArlen(mdlOwner);
        eArvalid           = mArvalid(mdlOwner);
        eArready[mdlOwner] = sIf.arready;
      end else begin
        eRready           = mRready(mdlOwner);
        eRvalid[mdlOwner] = sIf.rvalid;
        eRdata[mdlOwner]  = sIf.rdata;
        eRresp[mdlOwner]  = sIf.rresp;
        eRlast[mdlOwner]  = sIf.rlast;
      end
    end
    return {eAraddr, eArlen, eArvalid, eRready,
            eArready[0], eRdata[0], eRresp[0], eRlast[0], eRvalid[0],
            eArready[1], eRdata[1], eRresp[1], eRlast[1], eRvalid[1], eBusy};
  endfunction

  // Packs the DUT outputs in the same field order as expectedOutputs.
  function automatic logic [116:0] actualOutputs();
    return {sIf.araddr, sIf.arlen, sIf.arvalid, sIf.rready,
            m0If.arready, m0If.rdata, m0If.rresp, m0If.rlast, m0If.rvalid,
            m1If.arready, m1If.rdata, m1If.rresp, m1If.rlast, m1If.rvalid, busy};
  endfunction

  // Compares every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    checkOutput("cycle outputs", {11'b0, actualOutputs()}, {11'b0, expectedOutputs()});
  end

  // Logs observed at the DUT ports: accepted addresses in grant order, and
  // the delivered beats of each master.
  logic [31:0] grantLog [$];
  logic [31:0] m0Data [$];
  logic [31:0] m1Data [$];
  logic        m1Last [$];

  always @(negedge clk) begin
    if (resetn && sIf.arvalid && sIf.arready) grantLog.push_back(sIf.araddr);
    if (resetn && m0If.rvalid && m0If.rready) m0Data.push_back(m0If.rdata);
    if (resetn && m1If.rvalid && m1If.rready) begin
      m1Data.push_back(m1If.rdata);
      m1Last.push_back(m1If.rlast);
    end
  end

  // Requester stimulus. Each master presents the head of its queue and holds
  // it until its AR handshake completes.
  logic [31:0] q0Addr [$];
  logic [7:0]  q0Len [$];
  logic [31:0] q1Addr [$];
  logic [7:0]  q1Len [$];
  logic        toggle1 = 1'b0;
  logic        snapSArvalid, snapBusy, snapSRready, snapM1Rvalid;
  logic [31:0] snapSAraddr;

  function automatic void driveMasters();
    if (q0Addr.size() > 0) begin
      m0If.arvalid = 1'b1; m0If.araddr = q0Addr[0]; m0If.arlen = q0Len[0];
    end else begin
      m0If.arvalid = 1'b0;
    end
    if (q1Addr.size() > 0) begin
      m1If.arvalid = 1'b1; m1If.araddr = q1Addr[0]; m1If.arlen = q1Len[0];
    end else begin
      m1If.arvalid = 1'b0;
    end
  endfunction

  task automatic applyStimulus(input int m, input logic [31:0] addr, input logic [7:0] len);
    if (m == 0) begin
      q0Addr.push_back(addr); q0Len.push_back(len);
    end else begin
      q1Addr.push_back(addr); q1Len.push_back(len);
    end
    driveMasters();
  endtask

  // Advances one cycle. It samples at the falling edge and drives new inputs
  // 1 time unit after the rising edge.
  task automatic stepCycle();
    logic hs0, hs1;
    @(negedge clk);
    hs0 = m0If.arvalid && m0If.arready;
    hs1 = m1If.arvalid && m1If.arready;
    snapSArvalid = sIf.arvalid;
    snapSAraddr  = sIf.araddr;
    snapBusy     = busy;
    snapSRready  = sIf.rready;
    snapM1Rvalid = m1If.rvalid;
    @(posedge clk);
    #1;
    if (hs0) begin void'(q0Addr.pop_front()); void'(q0Len.pop_front()); end
    if (hs1) begin void'(q1Addr.pop_front()); void'(q1Len.pop_front()); end
    driveMasters();
    if (toggle1) m1If.rready = ~m1If.rready;
  endtask

  task automatic runUntilIdle(input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      stepCycle();
      if (q0Addr.size() == 0 && q1Addr.size() == 0 && !snapBusy) break;
    end
    checkOutput("drain", 128'(q0Addr.size() + q1Addr.size() + int'(snapBusy)), 128'(0));
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    resetn = 1'b0;
    q0Addr.delete(); q0Len.delete(); q1Addr.delete(); q1Len.delete();
    driveMasters();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g;
    int d;
    logic [31:0] exp4 [4];
    m0If.arvalid = 1'b0; m0If.araddr = '0; m0If.arlen = '0; m0If.rready = 1'b1;
    m1If.arvalid = 1'b0; m1If.araddr = '0; m1If.arlen = '0; m1If.rready = 1'b1;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", 128'(busy), 128'(0));
    checkOutput("reset s_arvalid", 128'(sIf.arvalid), 128'(0));
    resetn = 1'b1;

    // Single m0 read. The address reaches the bridge one cycle after the request.
    $display("[TB] single m0 read");
    applyStimulus(0, 32'h0, 8'd0);
    stepCycle();
    checkOutput("t1 s_arvalid before grant", 128'(snapSArvalid), 128'(0));
    stepCycle();
    checkOutput("t1 s_arvalid granted", 128'(snapSArvalid), 128'(1));
    checkOutput("t1 s_araddr", 128'(snapSAraddr), 128'(32'h0));
    runUntilIdle(50);
    checkOutput("t1 m0 beats", 128'(m0Data.size()), 128'(1));
    checkOutput("t1 m0 rdata", 128'((m0Data.size() > 0) ? m0Data[0] : 32'hdeadbeef),
                128'(32'h12345678));
    checkOutput("t1 m1 beats", 128'(m1Data.size()), 128'(0));
    checkOutput("t1 busy idle", 128'(snapBusy), 128'(0));

    // Simultaneous requests right after reset. m0 wins the first tie.
    $display("[TB] simultaneous requests");
    doReset();
    g = grantLog.size();
    applyStimulus(0, 32'h10, 8'd0);
    applyStimulus(1, 32'h20, 8'd0);
    runUntilIdle(50);
    checkOutput("t2 grant count", 128'(grantLog.size() - g), 128'(2));
    checkOutput("t2 first grant", 128'((grantLog.size() > g) ? grantLog[g] : 32'hdeadbeef),
                128'(32'h10));
    checkOutput("t2 second grant", 128'((grantLog.size() > g + 1) ? grantLog[g+1] : 32'hdeadbeef),
                128'(32'h20));

    // Both masters request continuously. The bridge stalls AR for three
    // cycles at first.
    $display("[TB] continuous requests");
    g = grantLog.size();
    arStall = 1'b1;
    applyStimulus(0, 32'h100, 8'd0);
    applyStimulus(0, 32'h140, 8'd0);
    applyStimulus(1, 32'h200, 8'd0);
    applyStimulus(1, 32'h240, 8'd0);
    repeat (3) stepCycle();
    arStall = 1'b0;
    runUntilIdle(100);
    if (FIXED_PRIO) begin
      exp4[0] = 32'h100; exp4[1] = 32'h140; exp4[2] = 32'h200; exp4[3] = 32'h240;
    end else begin
      exp4[0] = 32'h100; exp4[1] = 32'h200; exp4[2] = 32'h140; exp4[3] = 32'h240;
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t3 grant %0d", i),
                  128'((grantLog.size() > g + i) ? grantLog[g+i] : 32'hdeadbeef), 128'(exp4[i]));
    end

    // A stray s_rvalid while idle must be ignored.
    $display("[TB] spurious rvalid");
    spurious = 1'b1;
    repeat (2) stepCycle();
    checkOutput("t4 stray s_rready", 128'(snapSRready), 128'(0));
    checkOutput("t4 stray m1_rvalid", 128'(snapM1Rvalid), 128'(0));
    spurious = 1'b0;

    // A 4-beat m1 burst with m1_rready toggling every cycle.
    $display("[TB] burst with backpressure");
    d = m1Data.size();
    toggle1 = 1'b1;
    applyStimulus(1, 32'h300, 8'd3);
    runUntilIdle(100);
    toggle1 = 1'b0;
    m1If.rready = 1'b1;
    checkOutput("t5 beat count", 128'(m1Data.size() - d), 128'(4));
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t5 beat%0d data", i),
                  128'((m1Data.size() > d + i) ? m1Data[d+i] : 32'hdeadbeef),
                  128'(32'h12345678 + 32'h300 + 32'(i)));
      checkOutput($sformatf("t5 beat%0d rlast", i),
                  128'((m1Last.size() > d + i) ? m1Last[d+i] : 1'bx), 128'(i == 3));
    end

    // Reset while the second beat of a 4-beat burst is on the bus.
    $display("[TB] reset mid-burst");
    d = m1Data.size();
    applyStimulus(1, 32'h400, 8'd3);
    for (int i = 0; i < 50; i++) begin
      stepCycle();
      if (m1Data.size() == d + 1) break;
    end
    checkOutput("t6 first beat seen", 128'(m1Data.size() - d), 128'(1));
    resetn = 1'b0;
    stepCycle();
    checkOutput("t6 busy in reset", 128'(snapBusy), 128'(0));
    checkOutput("t6 m1_rvalid in reset", 128'(snapM1Rvalid), 128'(0));
    checkOutput("t6 s_rready in reset", 128'(snapSRready), 128'(0));
    resetn = 1'b1;
    stepCycle();
    checkOutput("t6 idle after reset", 128'(snapBusy), 128'(0));
    g = grantLog.size();
    applyStimulus(1, 32'h500, 8'd0);
    runUntilIdle(50);
    checkOutput("t6 m1 regrant", 128'((grantLog.size() > g) ? grantLog[g] : 32'hdeadbeef),
                128'(32'h500));
    checkOutput("t6 m1 data", 128'((m1Data.size() > 0) ? m1Data[m1Data.size()-1] : 32'hdeadbeef),
                128'(32'h12345678 + 32'h500));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
